// File: rtl/sequence_detect.sv
// Serial bit-pattern detector with registered one-cycle match flag.
// Optional saturating match counter enabled by SEQ_DETECT_COUNT_EN.
module sequence_detect #(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b0110,
   parameter bit                     OVERLAP     = 1'b1
) (
   input  logic       x,
   input  logic       clk,
   input  logic       reset,
   output logic       z
`ifdef SEQ_DETECT_COUNT_EN
   ,output logic [7:0] match_count
`endif
);

   localparam int FW = $clog2(PATTERN_LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] hist_q, hist_d;
   logic [FW-1:0]          fill_q, fill_d, fill_inc;
   logic                   z_q, z_d;
   logic                   match;

   always_comb begin
      hist_d   = {hist_q[PATTERN_LEN-2:0], x};
      fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      match    = (fill_inc == FULL) && (hist_d == PATTERN);
      fill_d   = fill_inc;
      // Non-overlapping mode demands N fresh bits after each hit.
      if (match && !OVERLAP) begin
         fill_d = '0;
      end
      z_d = match;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
      end
   end

   assign z = z_q;

`ifdef SEQ_DETECT_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (match && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_sequence_detect.sv
// Scoreboard bench for sequence_detect across four parameter sets.
// Counter checks are active when SEQ_DETECT_COUNT_EN is defined.
module tb_sequence_detect;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic x = 1'b0;
   logic [3:0] z;

   always #5 clk = ~clk;

`ifdef SEQ_DETECT_COUNT_EN
   logic [7:0] mc0, mc1, mc2, mc3;
`endif

   sequence_detect #(.PATTERN_LEN(4), .PATTERN(4'b0110), .OVERLAP(1'b1)) u0 (
      .x(x), .clk(clk), .reset(reset), .z(z[0])
`ifdef SEQ_DETECT_COUNT_EN
      , .match_count(mc0)
`endif
   );
   sequence_detect #(.PATTERN_LEN(4), .PATTERN(4'b0110), .OVERLAP(1'b0)) u1 (
      .x(x), .clk(clk), .reset(reset), .z(z[1])
`ifdef SEQ_DETECT_COUNT_EN
      , .match_count(mc1)
`endif
   );
   sequence_detect #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u2 (
      .x(x), .clk(clk), .reset(reset), .z(z[2])
`ifdef SEQ_DETECT_COUNT_EN
      , .match_count(mc2)
`endif
   );
   sequence_detect #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0)) u3 (
      .x(x), .clk(clk), .reset(reset), .z(z[3])
`ifdef SEQ_DETECT_COUNT_EN
      , .match_count(mc3)
`endif
   );

   typedef struct {
      logic [3:0] ez;
      int         ecnt[4];
   } exp_t;

   exp_t sb[$];

   logic [3:0] pat [4] = '{4'b0110, 4'b0110, 4'b1111, 4'b1111};
   bit         ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [15:0] sh [4];
   int          since [4];
   int          cnt [4];

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic xb, input logic rb);
      exp_t e;
      exp_t g;
      @(negedge clk);
      x = xb;
      reset = rb;
      for (int i = 0; i < 4; i++) begin
         if (rb) begin
            sh[i] = '0;
            since[i] = 0;
            cnt[i] = 0;
            e.ez[i] = 1'b0;
         end else begin
            sh[i] = {sh[i][14:0], xb};
            since[i]++;
            e.ez[i] = (since[i] >= 4) && (sh[i][3:0] == pat[i]);
            if (e.ez[i] && !ov[i]) since[i] = 0;
            if (e.ez[i] && cnt[i] < 255) cnt[i]++;
         end
         e.ecnt[i] = cnt[i];
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("z%0d", i), int'(z[i]), int'(g.ez[i]));
      end
`ifdef SEQ_DETECT_COUNT_EN
      chk("mc0", int'(mc0), g.ecnt[0]);
      chk("mc1", int'(mc1), g.ecnt[1]);
      chk("mc2", int'(mc2), g.ecnt[2]);
      chk("mc3", int'(mc3), g.ecnt[3]);
`endif
   endtask

   task automatic send(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i], 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         sh[i] = '0;
         since[i] = 0;
         cnt[i] = 0;
      end

      step(1'b0, 1'b1);
      chk("rst_z", int'(z), 0);

      send(16'b00110, 5);
      chk("tp1_hit", int'(z[0]), 1);
      send(16'b1000, 4);
      chk("tp1_tail", int'(z[0]), 0);

      step(1'b0, 1'b1);
      send(16'b0110, 4);
      chk("ov_hit4", int'(z[0]), 1);
      chk("nov_hit4", int'(z[1]), 1);
      send(16'b110, 3);
      chk("ov_hit7", int'(z[0]), 1);
      chk("nov_no7", int'(z[1]), 0);

      step(1'b0, 1'b1);
      send(16'b011, 3);
      step(1'b0, 1'b1);
      send(16'b0, 1);
      chk("mid_rst", int'(z[0]), 0);
      send(16'b0110, 4);
      chk("post_rst", int'(z[0]), 1);

      step(1'b0, 1'b1);
      send(16'b011, 3);
      step(1'b0, 1'b1);
      chk("collide", int'(z[0]), 0);
`ifdef SEQ_DETECT_COUNT_EN
      chk("collide_mc", int'(mc0), 0);
`endif

      send(16'b1111111, 7);
      chk("nov1111_7", int'(z[3]), 0);
      send(16'b1, 1);
      chk("nov1111_8", int'(z[3]), 1);

      step(1'b0, 1'b1);
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 1'b0);
         if (i == 3) chk("sat_b3", int'(z[2]), 0);
      end
      chk("sat_z300", int'(z[2]), 1);
`ifdef SEQ_DETECT_COUNT_EN
      chk("sat_mc", int'(mc2), 255);
`endif
      step(1'b0, 1'b0);
      chk("sat_end", int'(z[2]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
